// File: rtl/trap_ctrl.sv
// trap_ctrl
// ---------
// Trap sequencer sitting directly upstream of the machine-mode CSR file.
// It picks one event in IDLE (synchronous exception, then MRET, then an
// enabled interrupt), asks the pipeline to drain, pulses the CSR-file
// update for one cycle and finally issues a one-cycle fetch redirect to
// either the trap vector or mepc.
//
// Ports:
//   ctrl_clk, ctrl_reset      clock, asynchronous active-high reset
//   exc_valid/exc_cause/exc_pc   synchronous exception at commit
//   mret_req                  MRET reached commit
//   commit_pc                 return point used for interrupts
//   irq_ext/irq_soft/irq_timer   pending interrupt levels (mip)
//   mie_meie/mie_msie/mie_mtie   per-source enables (mie)
//   ctrl_mie                  global mstatus.MIE
//   mtvec, mepc               CSR values used to form the redirect target
//   flush_req / flush_ack     pipeline drain handshake
//   ctrl_trap, ctrl_mret      one-cycle update pulses to the CSR file
//   trap_pc, trap_info        mepc value and {is_interrupt, cause}
//   redirect_valid/redirect_pc   one-cycle fetch redirect
//   busy                      high whenever a sequence is in progress
//
// Build option:
//   TRAP_VECTORED_EN  when defined, interrupts taken with mtvec[1:0] = 1
//                     redirect to base + 4*cause; otherwise every trap
//                     goes to the base address.

module trap_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        ctrl_clk,
    input  logic        ctrl_reset,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic        mret_req,
    input  logic [31:0] commit_pc,
    input  logic        irq_ext,
    input  logic        irq_soft,
    input  logic        irq_timer,
    input  logic        mie_meie,
    input  logic        mie_msie,
    input  logic        mie_mtie,
    input  logic        ctrl_mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        flush_req,
    input  logic        flush_ack,
    output logic        ctrl_trap,
    output logic        ctrl_mret,
    output logic [31:0] trap_pc,
    output logic [4:0]  trap_info,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DRAIN    = 2'd1;
    localparam logic [1:0] COMMIT   = 2'd2;
    localparam logic [1:0] REDIRECT = 2'd3;

    logic [1:0]  state;

    // Event latched at the IDLE -> DRAIN transition, frozen until IDLE.
    logic        lat_mret;
    logic        lat_int;
    logic [3:0]  lat_cause;
    logic [31:0] lat_pc;

    // Arbitration result for the current cycle (only used in IDLE).
    logic        ev_any;
    logic        ev_mret;
    logic        ev_int;
    logic [3:0]  ev_cause;
    logic [31:0] ev_pc;

    logic [31:0] trap_base;
    logic [31:0] trap_target;

    assign busy = (state != IDLE);

    // Fixed-priority arbitration: exception beats MRET beats interrupts;
    // among interrupts external beats software beats timer.
    always_comb begin
        ev_any   = 1'b0;
        ev_mret  = 1'b0;
        ev_int   = 1'b0;
        ev_cause = 4'd0;
        ev_pc    = 32'd0;
        if (exc_valid) begin
            ev_any   = 1'b1;
            ev_cause = exc_cause;
            ev_pc    = exc_pc;
        end else if (mret_req) begin
            ev_any  = 1'b1;
            ev_mret = 1'b1;
        end else if (ctrl_mie) begin
            if (irq_ext && mie_meie) begin
                ev_any   = 1'b1;
                ev_int   = 1'b1;
                ev_cause = 4'd11;
                ev_pc    = commit_pc;
            end else if (irq_soft && mie_msie) begin
                ev_any   = 1'b1;
                ev_int   = 1'b1;
                ev_cause = 4'd3;
                ev_pc    = commit_pc;
            end else if (irq_timer && mie_mtie) begin
                ev_any   = 1'b1;
                ev_int   = 1'b1;
                ev_cause = 4'd7;
                ev_pc    = commit_pc;
            end
        end
    end

    assign trap_base = {mtvec[31:2], 2'b00};

    // Trap destination; the vectored form only applies to interrupts.
`ifdef TRAP_VECTORED_EN
    assign trap_target = (mtvec[1:0] == 2'b01 && lat_int)
                       ? trap_base + {26'd0, lat_cause, 2'b00}
                       : trap_base;
`else
    logic mtvec_mode_unused;
    assign mtvec_mode_unused = ^mtvec[1:0];
    assign trap_target       = trap_base;
`endif

    // Sequencer: IDLE -> DRAIN (wait flush_ack) -> COMMIT (CSR pulse)
    // -> REDIRECT (fetch pulse) -> IDLE. All outputs are registered here
    // so each pulse lines up exactly with its state.
    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state          <= IDLE;
            lat_mret       <= 1'b0;
            lat_int        <= 1'b0;
            lat_cause      <= 4'd0;
            lat_pc         <= 32'd0;
            flush_req      <= 1'b0;
            ctrl_trap      <= 1'b0;
            ctrl_mret      <= 1'b0;
            trap_pc        <= 32'd0;
            trap_info      <= 5'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    redirect_valid <= 1'b0;
                    redirect_pc    <= RESET_PC;
                    if (ev_any) begin
                        state     <= DRAIN;
                        flush_req <= 1'b1;
                        lat_mret  <= ev_mret;
                        lat_int   <= ev_int;
                        lat_cause <= ev_cause;
                        lat_pc    <= ev_pc;
                    end
                end
                DRAIN: begin
                    if (flush_ack) begin
                        state     <= COMMIT;
                        flush_req <= 1'b0;
                        if (lat_mret) begin
                            ctrl_mret <= 1'b1;
                        end else begin
                            ctrl_trap <= 1'b1;
                            trap_pc   <= {lat_pc[31:2], 2'b00};
                            trap_info <= {lat_int, lat_cause};
                        end
                    end
                end
                COMMIT: begin
                    state          <= REDIRECT;
                    ctrl_trap      <= 1'b0;
                    ctrl_mret      <= 1'b0;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= lat_mret ? mepc : trap_target;
                end
                REDIRECT: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                    redirect_pc    <= RESET_PC;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl
// ------------
// Self-checking bench for trap_ctrl. A small reference model decides from
// the current inputs which event should win and where the fetch should go,
// and each test task walks the handshake cycle by cycle comparing outputs.

module tb_trap_ctrl;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

    logic        ctrl_clk;
    logic        ctrl_reset;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        mret_req;
    logic [31:0] commit_pc;
    logic        irq_ext, irq_soft, irq_timer;
    logic        mie_meie, mie_msie, mie_mtie;
    logic        ctrl_mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        flush_req;
    logic        flush_ack;
    logic        ctrl_trap;
    logic        ctrl_mret;
    logic [31:0] trap_pc;
    logic [4:0]  trap_info;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Last values the CSR-facing outputs should be holding.
    logic [31:0] exp_trap_pc   = 32'd0;
    logic [4:0]  exp_trap_info = 5'd0;

    trap_ctrl #(.RESET_PC(TB_RESET_PC)) dut (
        .ctrl_clk      (ctrl_clk),
        .ctrl_reset    (ctrl_reset),
        .exc_valid     (exc_valid),
        .exc_cause     (exc_cause),
        .exc_pc        (exc_pc),
        .mret_req      (mret_req),
        .commit_pc     (commit_pc),
        .irq_ext       (irq_ext),
        .irq_soft      (irq_soft),
        .irq_timer     (irq_timer),
        .mie_meie      (mie_meie),
        .mie_msie      (mie_msie),
        .mie_mtie      (mie_mtie),
        .ctrl_mie      (ctrl_mie),
        .mtvec         (mtvec),
        .mepc          (mepc),
        .flush_req     (flush_req),
        .flush_ack     (flush_ack),
        .ctrl_trap     (ctrl_trap),
        .ctrl_mret     (ctrl_mret),
        .trap_pc       (trap_pc),
        .trap_info     (trap_info),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .busy          (busy)
    );

    initial begin
        ctrl_clk = 1'b0;
        forever #5 ctrl_clk = ~ctrl_clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge ctrl_clk);
        #1;
    endtask

    task automatic clear_events;
        exc_valid = 1'b0;
        mret_req  = 1'b0;
        irq_ext   = 1'b0;
        irq_soft  = 1'b0;
        irq_timer = 1'b0;
    endtask

    // Reference: which event wins with the inputs as they stand now.
    function automatic void model_event(output bit any, output bit is_mret,
                                        output logic [4:0] info,
                                        output logic [31:0] pc);
        any = 1'b1; is_mret = 1'b0; info = 5'd0; pc = 32'd0;
        if (exc_valid) begin
            info = {1'b0, exc_cause};
            pc   = exc_pc;
        end else if (mret_req) begin
            is_mret = 1'b1;
        end else if (ctrl_mie && irq_ext && mie_meie) begin
            info = 5'd16 + 5'd11;  pc = commit_pc;
        end else if (ctrl_mie && irq_soft && mie_msie) begin
            info = 5'd16 + 5'd3;   pc = commit_pc;
        end else if (ctrl_mie && irq_timer && mie_mtie) begin
            info = 5'd16 + 5'd7;   pc = commit_pc;
        end else begin
            any = 1'b0;
        end
    endfunction

    // Reference: where fetch should go once the event is handled.
    function automatic logic [31:0] model_target(input bit is_mret,
                                                 input logic [4:0] info);
        logic [31:0] base;
        if (is_mret) return mepc;
        base = mtvec - (mtvec % 4);
`ifdef TRAP_VECTORED_EN
        if ((mtvec % 4) == 1 && info[4])
            base = base + 4 * 32'(info[3:0]);
`endif
        return base;
    endfunction

    // Apply already-driven inputs at the next edge and follow the whole
    // sequence, acknowledging the drain after ack_delay extra cycles.
    // With perturb set, exception/interrupt inputs are scrambled during
    // the drain to confirm the latched event is not disturbed.
    task automatic run_transaction(input int ack_delay, input bit perturb,
                                   input string tag);
        bit          any, is_mret;
        logic [4:0]  info;
        logic [31:0] pc, tgt;
        model_event(any, is_mret, info, pc);
        tgt = model_target(is_mret, info);
        tick;
        if (!any) begin
            total++;
            if (busy !== 1'b0 || flush_req !== 1'b0) begin
                bad++;
                $display("[TB] FAIL %s no_event: busy=%b flush_req=%b want 0/0", tag, busy, flush_req);
            end
            clear_events;
            return;
        end
        for (int i = 0; i <= ack_delay; i++) begin
            total++;
            if (flush_req !== 1'b1 || busy !== 1'b1 || ctrl_trap !== 1'b0 || ctrl_mret !== 1'b0) begin
                bad++;
                $display("[TB] FAIL %s drain[%0d]: flush_req=%b busy=%b trap=%b mret=%b want 1/1/0/0",
                         tag, i, flush_req, busy, ctrl_trap, ctrl_mret);
            end
            if (perturb && i < ack_delay) begin
                exc_cause = 4'($urandom);
                exc_pc    = $urandom;
                commit_pc = $urandom;
            end
            if (i == ack_delay) begin
                flush_ack = 1'b1;
                clear_events;
            end
            tick;
        end
        flush_ack = 1'b0;
        if (!is_mret) begin
            exp_trap_pc   = pc & 32'hFFFF_FFFC;
            exp_trap_info = info;
        end
        total++;
        if (ctrl_trap !== !is_mret || ctrl_mret !== is_mret || flush_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s commit_pulse: trap=%b mret=%b flush_req=%b want %b/%b/0",
                     tag, ctrl_trap, ctrl_mret, flush_req, !is_mret, is_mret);
        end
        total++;
        if (trap_pc !== exp_trap_pc) begin
            bad++;
            $display("[TB] FAIL %s trap_pc: got %h want %h", tag, trap_pc, exp_trap_pc);
        end
        total++;
        if (trap_info !== exp_trap_info) begin
            bad++;
            $display("[TB] FAIL %s trap_info: got %h want %h", tag, trap_info, exp_trap_info);
        end
        tick;
        total++;
        if (redirect_valid !== 1'b1 || ctrl_trap !== 1'b0 || ctrl_mret !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s redirect_pulse: rv=%b trap=%b mret=%b busy=%b want 1/0/0/1",
                     tag, redirect_valid, ctrl_trap, ctrl_mret, busy);
        end
        total++;
        if (redirect_pc !== tgt) begin
            bad++;
            $display("[TB] FAIL %s redirect_pc: got %h want %h", tag, redirect_pc, tgt);
        end
        tick;
        total++;
        if (busy !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== TB_RESET_PC) begin
            bad++;
            $display("[TB] FAIL %s back_idle: busy=%b rv=%b pc=%h want 0/0/%h",
                     tag, busy, redirect_valid, redirect_pc, TB_RESET_PC);
        end
    endtask

    task automatic test_reset;
        ctrl_reset = 1'b1;
        clear_events;
        exc_cause = 4'd0; exc_pc = 32'd0; commit_pc = 32'd0;
        mie_meie = 1'b0; mie_msie = 1'b0; mie_mtie = 1'b0; ctrl_mie = 1'b0;
        mtvec = 32'd0; mepc = 32'd0; flush_ack = 1'b0;
        #2;
        total++;
        if (busy !== 1'b0 || flush_req !== 1'b0 || ctrl_trap !== 1'b0 || ctrl_mret !== 1'b0 ||
            redirect_valid !== 1'b0 || redirect_pc !== TB_RESET_PC || trap_pc !== 32'd0 || trap_info !== 5'd0) begin
            bad++;
            $display("[TB] FAIL reset_values: busy=%b fr=%b trap=%b mret=%b rv=%b rpc=%h tpc=%h info=%h",
                     busy, flush_req, ctrl_trap, ctrl_mret, redirect_valid, redirect_pc, trap_pc, trap_info);
        end
        tick;
        ctrl_reset = 1'b0;
        tick;
    endtask

    task automatic test_exception;
        mtvec = 32'h200; exc_cause = 4'd2; exc_pc = 32'h100; exc_valid = 1'b1;
        run_transaction(0, 1'b0, "exception");
    endtask

    task automatic test_interrupt_priority;
        mtvec = 32'h201; commit_pc = 32'h44;
        mie_meie = 1'b1; mie_mtie = 1'b1; ctrl_mie = 1'b1;
        irq_ext = 1'b1; irq_timer = 1'b1;
        run_transaction(0, 1'b0, "irq_priority");
    endtask

    task automatic test_mie_masked;
        ctrl_mie = 1'b0; mie_meie = 1'b1; mie_mtie = 1'b1;
        irq_ext = 1'b1; irq_timer = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            total++;
            if (busy !== 1'b0 || flush_req !== 1'b0) begin
                bad++;
                $display("[TB] FAIL mie_masked[%0d]: busy=%b flush_req=%b want 0/0", i, busy, flush_req);
            end
        end
        clear_events;
    endtask

    task automatic test_mret_delayed;
        mepc = 32'h88; mret_req = 1'b1;
        run_transaction(5, 1'b0, "mret_delayed");
    endtask

    task automatic test_simultaneous;
        ctrl_mie = 1'b1; mie_msie = 1'b1; irq_soft = 1'b1;
        mret_req = 1'b1; exc_valid = 1'b1; exc_cause = 4'd13; exc_pc = 32'h3F7;
        mtvec = 32'h8000_0001; mepc = 32'h1234;
        run_transaction(1, 1'b1, "simultaneous");
    endtask

    task automatic test_reset_mid_drain;
        exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h500;
        tick;
        total++;
        if (flush_req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_drain_pre: flush_req=%b want 1", flush_req);
        end
        #2;
        ctrl_reset = 1'b1;
        clear_events;
        #1;
        exp_trap_pc = 32'd0; exp_trap_info = 5'd0;
        total++;
        if (flush_req !== 1'b0 || busy !== 1'b0 || ctrl_trap !== 1'b0 || redirect_pc !== TB_RESET_PC) begin
            bad++;
            $display("[TB] FAIL reset_drain_async: fr=%b busy=%b trap=%b rpc=%h want 0/0/0/%h",
                     flush_req, busy, ctrl_trap, redirect_pc, TB_RESET_PC);
        end
        tick;
        ctrl_reset = 1'b0;
        flush_ack  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            total++;
            if (ctrl_trap !== 1'b0 || ctrl_mret !== 1'b0 || busy !== 1'b0 || redirect_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_drain_after[%0d]: trap=%b mret=%b busy=%b rv=%b want 0",
                         i, ctrl_trap, ctrl_mret, busy, redirect_valid);
            end
        end
        flush_ack = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] r;
        for (int n = 0; n < 60; n++) begin
            exc_valid = ($urandom_range(0, 3) == 0);
            mret_req  = ($urandom_range(0, 3) == 0);
            exc_cause = 4'($urandom);
            exc_pc    = $urandom;
            commit_pc = $urandom;
            r         = $urandom;
            irq_ext   = r[0]; irq_soft = r[1]; irq_timer = r[2];
            mie_meie  = r[3]; mie_msie = r[4]; mie_mtie  = r[5];
            ctrl_mie  = (r[7:6] != 2'b00);
            r         = $urandom;
            mtvec     = {r[31:2], 1'b0, r[0]};
            mepc      = $urandom;
            run_transaction(int'($urandom_range(0, 3)), r[1], "random");
        end
    endtask

    task automatic test_back_to_back;
        ctrl_mie = 1'b1; mie_mtie = 1'b1; mtvec = 32'h401;
        for (int n = 0; n < 3; n++) begin
            irq_timer = 1'b1; commit_pc = 32'h600 + 32'(n * 8);
            run_transaction(0, 1'b0, "back_to_back");
        end
        clear_events;
    endtask

    initial begin
        test_reset;
        test_exception;
        test_interrupt_priority;
        test_mie_masked;
        test_mret_delayed;
        test_simultaneous;
        test_back_to_back;
        test_reset_mid_drain;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap sequencer that sits directly upstream of the machine-mode CSR file and drives its ctrl_trap, ctrl_mret, trap_pc and trap_info inputs.
- Arbitrates synchronous exceptions, MRET requests and the three M-mode interrupt lines.
- Drains the pipeline through a flush handshake, pulses the CSR-file update, then issues a one-cycle fetch redirect to the trap vector or to mepc.

Parameters:
RESET_PC, 32'h00000000, redirect_pc value held in reset and while idle.

Ports:
ctrl_clk  input  1  clock
ctrl_reset  input  1  reset; asynchronous, active-high
exc_valid  input  1  synchronous exception at commit (level, held until flush_ack)
exc_cause  input  4  exception code (0..15)
exc_pc  input  32  PC of faulting instruction
mret_req  input  1  MRET reached commit (held until flush_ack)
commit_pc  input  32  PC of next instruction to commit (interrupt return point)
irq_ext, irq_soft, irq_timer  input  1 each  pending levels (mip.MEIP/MSIP/MTIP)
mie_meie, mie_msie, mie_mtie  input  1 each  per-source enables from mie
ctrl_mie  input  1  mstatus.MIE from CSR file
mtvec  input  32  trap vector CSR value
mepc  input  32  mepc CSR value
flush_req  output  1  request pipeline drain
flush_ack  input  1  pipeline drained; all prior CSR writes visible
ctrl_trap  output  1  one-cycle trap pulse to CSR file
ctrl_mret  output  1  one-cycle mret pulse to CSR file
trap_pc  output  32  value for mepc
trap_info  output  5  {is_interrupt, cause[3:0]}
redirect_valid  output  1  one-cycle fetch redirect
redirect_pc  output  32  redirect target
busy  output  1  state != IDLE

Behaviour:
- FSM states: IDLE, DRAIN, COMMIT, REDIRECT. busy = (state != IDLE).
- Reset values (async): state = IDLE; flush_req, ctrl_trap, ctrl_mret, redirect_valid = 0; trap_pc = 0; trap_info = 0; redirect_pc = RESET_PC. Reset asserted mid-sequence aborts immediately to these values; no pulse is emitted afterwards.
- IDLE arbitration, in priority order; only the winner is latched:
  1. exc_valid: kind = TRAP, cause = {0, exc_cause}, pc = exc_pc.
  2. mret_req: kind = MRET.
  3. Interrupt, only if ctrl_mie = 1. MEI (irq_ext & mie_meie) gives cause 11, else MSI gives cause 3, else MTI gives cause 7. is_interrupt = 1, pc = commit_pc.
- IDLE to DRAIN when any event wins. Latched kind, cause and pc are frozen until return to IDLE. Inputs are ignored outside IDLE.
- DRAIN: flush_req = 1. Stay while flush_ack = 0, no timeout. flush_ack = 1 moves to COMMIT next edge.
- COMMIT (exactly 1 cycle):
  - Kind TRAP: ctrl_trap = 1, trap_pc = latched pc with bits [1:0] forced to 0, trap_info = latched {is_interrupt, cause}.
  - Kind MRET: ctrl_mret = 1, ctrl_trap = 0.
  - ctrl_trap and ctrl_mret are never both high.
- REDIRECT (exactly 1 cycle): redirect_valid = 1.
  - Kind MRET: redirect_pc = mepc sampled this cycle.
  - Kind TRAP: redirect_pc = {mtvec[31:2], 2'b00}, plus vector offset (see Optional Feature).
  - Next state IDLE.
- Latency: event sampled at edge k; flush_req is high in cycle k+1. With flush_ack = 1 in that cycle, ctrl_trap/ctrl_mret pulse in k+2, redirect in k+3, IDLE in k+4. Earliest re-arbitration is at edge k+4.
- An interrupt newly pending while busy is taken only after return to IDLE, and only if ctrl_mie is still set. The CSR file clears MIE on ctrl_trap, so back-to-back interrupts are blocked.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- Outputs are registered (Moore). trap_pc and trap_info hold their last values outside COMMIT.

Optional Feature:
TRAP_VECTORED_EN:
- Defined: when mtvec[1:0] = 1 and the latched trap is an interrupt, redirect_pc = {mtvec[31:2], 2'b00} + 4*cause. Exceptions always go to the base.
- Undefined: mtvec[1:0] is ignored and every trap redirects to the base.

Test Plan:
- exc_valid = 1, exc_cause = 2, exc_pc = 32'h100, mtvec = 32'h200, flush_ack tied 1 -> flush_req at k+1; ctrl_trap at k+2 with trap_pc = 32'h100, trap_info = 5'h02; redirect_pc = 32'h200 at k+3; busy low at k+4.
- irq_timer = irq_ext = 1, both enabled, ctrl_mie = 1, commit_pc = 32'h44 -> trap_info = 5'h1B, trap_pc = 32'h44. With TRAP_VECTORED_EN and mtvec = 32'h201, redirect_pc = 32'h22C; without it, 32'h200.
- Same interrupts but ctrl_mie = 0 -> no flush_req and busy stays 0 for 20 cycles.
- mret_req = 1, mepc = 32'h88, flush_ack delayed 5 cycles -> flush_req high 6 cycles; then ctrl_mret 1 cycle, ctrl_trap 0; redirect_pc = 32'h88.
- exc_valid and mret_req asserted together, plus irq_soft -> exception served (ctrl_trap, trap_info = {0, exc_cause}); no ctrl_mret.
- ctrl_reset pulsed during DRAIN -> all outputs 0 and redirect_pc = RESET_PC immediately (async). No ctrl_trap follows even though flush_ack rises afterwards.
